// File: rtl/mips32_mem_pkg.sv
// Shared types for the MIPS32 unified-memory arbiter: access owners, FSM states, default widths.
package mips32_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_DBG} owner_e;
   typedef enum logic {S_IDLE, S_WAIT} state_e;

   // pick vector is {dbg, dm, if}, at most one bit set
   function automatic owner_e pick_to_owner(input logic [2:0] pick);
      unique case (pick)
         3'b100:  return OWN_DBG;
         3'b010:  return OWN_DM;
         3'b001:  return OWN_IF;
         default: return OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mips32_mem_prio_pick.sv
// Combinational winner select: DBG > DM > IF, except a starving IF beats DM (never DBG).
module mips32_mem_prio_pick (
   input  logic       if_req_i,
   input  logic       dm_req_i,
   input  logic       dbg_req_i,
   input  logic       starve_i,
   output logic [2:0] pick_o
);

   always_comb begin
      pick_o = 3'b000;
      if (dbg_req_i) begin
         pick_o = 3'b100;
      end else if (if_req_i && (starve_i || !dm_req_i)) begin
         pick_o = 3'b001;
      end else if (dm_req_i) begin
         pick_o = 3'b010;
      end
   end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares the single-ported unified memory between IF, DM and DBG: one access in flight,
// fixed MEM_LAT read latency, next access may launch in the response cycle.
module mips32_mem_arbiter
   import mips32_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halted,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned LatW = $clog2(MEM_LAT + 1);
   localparam int unsigned StvW = $clog2(STARVE_MAX + 1);
   localparam logic [LatW-1:0] LatLast = LatW'(MEM_LAT - 1);
   localparam logic [StvW-1:0] StvMax  = StvW'(STARVE_MAX);

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
   logic [StvW-1:0] starve_cnt_q, starve_cnt_d;

   logic       if_eff;
   logic       resp;
   logic       resp_ok;
   logic       launch;
   logic [2:0] pick;

   assign if_eff  = if_req & ~halted;
   assign resp    = (state_q == S_WAIT) && (lat_cnt_q == LatLast);
   assign resp_ok = resp && !rst;
   // a launch slot is an idle cycle or the response cycle of the current access
   assign launch  = ((state_q == S_IDLE) || resp) && (pick != 3'b000) && !rst;

   mips32_mem_prio_pick u_pick (
      .if_req_i  (if_eff),
      .dm_req_i  (dm_req),
      .dbg_req_i (dbg_req),
      .starve_i  (starve_cnt_q == StvMax),
      .pick_o    (pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_NONE;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      if (launch) begin
         state_d   = S_WAIT;
         owner_d   = pick_to_owner(pick);
         lat_cnt_d = '0;
      end else if (resp) begin
         state_d   = S_IDLE;
         owner_d   = OWN_NONE;
         lat_cnt_d = '0;
      end else if (state_q == S_WAIT) begin
         lat_cnt_d = lat_cnt_q + 1'b1;
      end
      if (!if_eff || (launch && pick[0])) begin
         starve_cnt_d = '0;
      end else if (launch && pick[1] && (starve_cnt_q != StvMax)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      if_gnt     = launch & pick[0];
      dm_gnt     = launch & pick[1];
      dbg_gnt    = launch & pick[2];
      mem_en     = launch;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (launch) begin
         unique case (pick)
            3'b100: begin
               mem_we    = dbg_we;
               mem_addr  = dbg_addr;
               mem_wdata = dbg_wdata;
            end
            3'b010: begin
               mem_we    = dm_we;
               mem_addr  = dm_addr;
               mem_wdata = dm_wdata;
            end
            3'b001:  mem_addr = if_addr;
            default: mem_we   = 1'b0;
         endcase
      end
      if_rvalid  = resp_ok && (owner_q == OWN_IF);
      dm_rvalid  = resp_ok && (owner_q == OWN_DM);
      dbg_rvalid = resp_ok && (owner_q == OWN_DBG);
      rdata      = resp_ok ? mem_rdata : '0;
      busy       = (state_q == S_WAIT) && !rst;
   end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: two DUTs (MEM_LAT 1 and 3) with memory models, one selected at a
// time; a timestamp-based reference model predicts grants, responses and memory contents.
module tb_mips32_mem_arbiter;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, halted, mem_clr;
   logic          if_req, dm_req, dm_we, dbg_req, dbg_we;
   logic [AW-1:0] if_addr, dm_addr, dbg_addr;
   logic [DW-1:0] dm_wdata, dbg_wdata;
   int            sel, lat;

   logic [1:0]    rst_a, if_gnt_a, if_rv_a, dm_gnt_a, dm_rv_a, dbg_gnt_a, dbg_rv_a;
   logic [1:0]    en_a, we_a, busy_a;
   logic [AW-1:0] addr_a [2];
   logic [DW-1:0] wdata_a [2];
   logic [DW-1:0] rdata_a [2];
   logic [DW-1:0] mrdata_a [2];
   logic [2:0]    stv_a [2];

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      localparam int unsigned Lat = (g == 0) ? 1 : 3;
      logic [DW-1:0] mem [1024];
      logic [DW-1:0] pipe [Lat];

      assign rst_a[g] = rst || (sel != g);

      mips32_mem_arbiter #(
         .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(Lat), .STARVE_MAX(SMAX)
      ) u_dut (
         .clk(clk), .rst(rst_a[g]), .halted(halted),
         .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a[g]), .if_rvalid(if_rv_a[g]),
         .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
         .dm_gnt(dm_gnt_a[g]), .dm_rvalid(dm_rv_a[g]),
         .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
         .dbg_gnt(dbg_gnt_a[g]), .dbg_rvalid(dbg_rv_a[g]),
         .rdata(rdata_a[g]), .mem_en(en_a[g]), .mem_we(we_a[g]), .mem_addr(addr_a[g]),
         .mem_wdata(wdata_a[g]), .mem_rdata(mrdata_a[g]), .busy(busy_a[g])
      );

      assign stv_a[g] = u_dut.starve_cnt_q;

      always @(posedge clk) begin
         if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
         end else if (en_a[g] && we_a[g]) begin
            mem[addr_a[g]] <= wdata_a[g];
         end
         pipe[0] <= en_a[g] ? mem[addr_a[g]] : 32'hdead_beef;
         for (int i = 1; i < int'(Lat); i++) pipe[i] <= pipe[i-1];
      end
      assign mrdata_a[g] = pipe[Lat-1];
   end

   // requester-side state: a pending request is held until the model says it was granted
   logic          pend_if, pend_dm, pend_dbg, we_dm, we_dbg;
   logic [AW-1:0] a_if, a_dm, a_dbg;
   logic [DW-1:0] wd_dm, wd_dbg;

   // reference model: at most one access outstanding, answered at launch cycle + latency
   logic [DW-1:0] ref_mem [int];
   bit            m_busy, m_wr;
   int            m_due, m_owner, m_starve, cyc;
   logic [DW-1:0] m_data;

   logic [18:0]   exp_ctl, obs_ctl;
   logic [63:0]   exp_dat, obs_dat;
   logic [2:0]    obs_gnt, obs_rv, obs_stv;
   int            n_gnt [3];
   int            n_rv [3];
   logic [DW-1:0] last_rd [3];
   int            g_order [$];
   int            g_cyc [$];
   int            n_chk, n_fail;

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      int key = sel * 1024 + int'(a);
      return ref_mem.exists(key) ? ref_mem[key] : '0;
   endfunction

   function automatic bit active();
      return (pend_if && !halted) || pend_dm || pend_dbg || m_busy;
   endfunction

   task automatic clr_counts();
      for (int k = 0; k < 3; k++) begin
         n_gnt[k] = 0;
         n_rv[k]  = 0;
      end
      g_order.delete();
      g_cyc.delete();
   endtask

   // drive held requests, sample DUT at negedge, advance the model one cycle
   task automatic step();
      int            w;
      logic          eff_if, ewe, ebusy, een, chk_rd, chk_wd;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd, erd;
      logic [2:0]    egnt, erv;
      if_req = pend_if;  if_addr = a_if;
      dm_req = pend_dm;  dm_we = we_dm;   dm_addr = a_dm;   dm_wdata = wd_dm;
      dbg_req = pend_dbg; dbg_we = we_dbg; dbg_addr = a_dbg; dbg_wdata = wd_dbg;
      @(negedge clk);
      obs_gnt = {dbg_gnt_a[sel], dm_gnt_a[sel], if_gnt_a[sel]};
      obs_rv  = {dbg_rv_a[sel], dm_rv_a[sel], if_rv_a[sel]};
      obs_stv = stv_a[sel];
      eff_if = pend_if && !halted;
      w = -1; erv = '0; ea = '0; ewe = 1'b0; ewd = '0; erd = '0; ebusy = 1'b0;
      chk_rd = rst; chk_wd = rst;
      if (rst) begin
         m_busy   = 1'b0;
         m_starve = 0;
      end else begin
         ebusy = m_busy;
         if (m_busy && m_due == cyc) begin
            erv    = 3'(1 << m_owner);
            erd    = m_data;
            chk_rd = !m_wr;
            m_busy = 1'b0;
         end
         if (!m_busy) begin
            if (pend_dbg) w = 2;
            else if (pend_dm && !(eff_if && m_starve >= SMAX)) w = 1;
            else if (eff_if) w = 0;
         end
         if (w == 2) begin ea = a_dbg; ewe = we_dbg; ewd = wd_dbg; pend_dbg = 1'b0; end
         if (w == 1) begin ea = a_dm;  ewe = we_dm;  ewd = wd_dm;  pend_dm  = 1'b0; end
         if (w == 0) begin ea = a_if;  pend_if = 1'b0; end
         if (w >= 0) begin
            chk_wd  = ewe;
            m_busy  = 1'b1;
            m_due   = cyc + lat;
            m_owner = w;
            m_wr    = ewe;
            m_data  = ref_rd(ea);
            if (ewe) ref_mem[sel * 1024 + int'(ea)] = ewd;
         end
         if (w == 0 || !eff_if) m_starve = 0;
         else if (w == 1) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      end
      egnt = (w >= 0) ? 3'(1 << w) : 3'b000;
      een  = (w >= 0);
      exp_ctl = {egnt, erv, een, ewe, ebusy, ea};
      obs_ctl = {obs_gnt, obs_rv, en_a[sel], (een || rst) ? we_a[sel] : 1'b0, busy_a[sel],
                 (een || rst) ? addr_a[sel] : {AW{1'b0}}};
      exp_dat = {chk_rd ? erd : 32'h0, chk_wd ? ewd : 32'h0};
      obs_dat = {chk_rd ? rdata_a[sel] : 32'h0, chk_wd ? wdata_a[sel] : 32'h0};
      for (int k = 0; k < 3; k++) begin
         if (obs_gnt[k]) begin
            n_gnt[k]++;
            g_order.push_back(k);
            g_cyc.push_back(cyc);
         end
         if (obs_rv[k]) begin
            n_rv[k]++;
            last_rd[k] = rdata_a[sel];
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr_counts();
      pend_if = 1'b1;  a_if  = AW'($urandom);
      pend_dm = 1'b1;  a_dm  = AW'($urandom_range(0, 15)); we_dm = 1'($urandom); wd_dm = $urandom;
      pend_dbg = 1'b1; a_dbg = AW'($urandom_range(0, 15)); we_dbg = 1'b0;
      rst = 1'b1;
      repeat (3) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL reset ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL reset data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
      end
      n_chk++; if (n_gnt[0] + n_gnt[1] + n_gnt[2] !== 0) begin n_fail++;
         $display("FAIL reset grants: got %0d want 0", n_gnt[0] + n_gnt[1] + n_gnt[2]); end
      rst = 1'b0;
      for (int k = 0; k < 60 && active(); k++) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL reset_drain ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL reset_drain data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
      end
      n_chk++; if (active()) begin n_fail++;
         $display("FAIL reset_drain timeout: got pending want idle"); end
   endtask

   task automatic test_dbg_wr_rd();
      clr_counts();
      for (int p = 0; p < 2; p++) begin
         pend_dbg = 1'b1; a_dbg = AW'(200); we_dbg = (p == 0); wd_dbg = 32'h4;
         for (int k = 0; k < 40 && active(); k++) begin
            step();
            n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
               $display("FAIL dbg_wr_rd ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
            n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
               $display("FAIL dbg_wr_rd data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
         end
      end
      n_chk++; if (n_gnt[2] !== 2 || n_rv[2] !== 2) begin n_fail++;
         $display("FAIL dbg_wr_rd counts: got gnt %0d rv %0d want 2 2", n_gnt[2], n_rv[2]); end
      n_chk++; if (last_rd[2] !== 32'h4) begin n_fail++;
         $display("FAIL dbg_wr_rd rdata: got %h want 00000004", last_rd[2]); end
   endtask

   task automatic test_if_dm_same();
      clr_counts();
      pend_if = 1'b1; a_if = AW'($urandom_range(300, 400));
      pend_dm = 1'b1; a_dm = AW'(200); we_dm = 1'b0;
      for (int k = 0; k < 40 && active(); k++) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL if_dm_same ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL if_dm_same data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
      end
      n_chk++;
      if (g_order.size() != 2 || g_order[0] != 1 || g_order[1] != 0 || g_cyc[1] - g_cyc[0] != lat)
      begin
         n_fail++;
         $display("FAIL if_dm_same order: got %p at %p want DM then IF %0d cycles apart",
                  g_order, g_cyc, lat);
      end
      n_chk++; if (last_rd[1] !== 32'h4) begin n_fail++;
         $display("FAIL if_dm_same load: got %h want 00000004", last_rd[1]); end
   endtask

   task automatic test_starve();
      int  nst = 0;
      bit  if_prev = 1'b0;
      clr_counts();
      pend_if = 1'b1; a_if = AW'($urandom_range(0, 1023));
      for (int k = 0; k < 100 && (active() || nst < 8); k++) begin
         if (!pend_dm && nst < 8) begin
            pend_dm = 1'b1; we_dm = 1'b1; a_dm = AW'(198 + nst); wd_dm = $urandom; nst++;
         end
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL starve ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL starve data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
         if (obs_gnt[0]) begin
            n_chk++; if (obs_stv !== 3'(SMAX)) begin n_fail++;
               $display("FAIL starve cnt_at_if: got %0d want %0d", obs_stv, SMAX); end
         end
         if (if_prev) begin
            n_chk++; if (obs_stv !== 3'd0) begin n_fail++;
               $display("FAIL starve cnt_after_if: got %0d want 0", obs_stv); end
         end
         if_prev = obs_gnt[0];
      end
      n_chk++; if (g_order.size() != 9 || g_order[4] != 0 || n_gnt[1] != 8) begin n_fail++;
         $display("FAIL starve order: got %p want IF as 5th of 9 grants", g_order); end
   endtask

   task automatic test_all_three();
      clr_counts();
      pend_dbg = 1'b1; a_dbg = AW'(200); we_dbg = 1'b0;
      pend_dm = 1'b1; a_dm = AW'($urandom_range(300, 399)); we_dm = 1'b1; wd_dm = $urandom;
      pend_if = 1'b1; a_if = AW'($urandom_range(0, 1023));
      for (int k = 0; k < 60 && active(); k++) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL all_three ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL all_three data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
      end
      n_chk++; if (g_order.size() != 3 || g_order[0] != 2 || g_order[1] != 1 || g_order[2] != 0)
      begin n_fail++; $display("FAIL all_three order: got %p want DBG DM IF", g_order); end
      n_chk++; if (n_rv[0] != 1 || n_rv[1] != 1 || n_rv[2] != 1) begin n_fail++;
         $display("FAIL all_three rvalid: got if %0d dm %0d dbg %0d want 1 each",
                  n_rv[0], n_rv[1], n_rv[2]); end
   endtask

   task automatic test_halted();
      clr_counts();
      pend_if = 1'b1; a_if = AW'($urandom_range(0, 1023));
      for (int k = 0; k < 10 && n_gnt[0] == 0; k++) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL halted ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
      end
      halted = 1'b1;
      pend_if = 1'b1; a_if = AW'($urandom_range(0, 1023));
      pend_dm = 1'b1; a_dm = AW'(200); we_dm = 1'b0;
      repeat (4 * lat + 4) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL halted ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL halted data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
      end
      n_chk++; if (n_gnt[0] != 1 || n_rv[0] != 1 || n_rv[1] != 1) begin n_fail++;
         $display("FAIL halted counts: got if_gnt %0d if_rv %0d dm_rv %0d want 1 1 1",
                  n_gnt[0], n_rv[0], n_rv[1]); end
      halted = 1'b0;
      for (int k = 0; k < 40 && active(); k++) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL unhalt ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
      end
      n_chk++; if (n_gnt[0] != 2) begin n_fail++;
         $display("FAIL unhalt if_gnt: got %0d want 2", n_gnt[0]); end
   endtask

   task automatic test_reset_mid();
      clr_counts();
      pend_dm = 1'b1; a_dm = AW'(200); we_dm = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
         $display("FAIL reset_mid ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
      rst = 1'b0;
      repeat (5) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL reset_mid ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
      end
      n_chk++; if (n_rv[0] + n_rv[1] + n_rv[2] != 0) begin n_fail++;
         $display("FAIL reset_mid rvalid: got %0d want 0", n_rv[0] + n_rv[1] + n_rv[2]); end
      pend_if = 1'b1; a_if = AW'($urandom_range(0, 1023));
      step();
      n_chk++; if (obs_gnt !== 3'b001) begin n_fail++;
         $display("FAIL reset_mid first_gnt: got %b want 001", obs_gnt); end
      for (int k = 0; k < 20 && active(); k++) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL reset_mid ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         if (!pend_if && $urandom_range(0, 2) == 0) begin
            pend_if = 1'b1; a_if = AW'($urandom_range(0, 15));
         end
         if (!pend_dm && $urandom_range(0, 2) == 0) begin
            pend_dm = 1'b1; a_dm = AW'($urandom_range(0, 15)); we_dm = 1'($urandom);
            wd_dm = $urandom;
         end
         if (!pend_dbg && $urandom_range(0, 5) == 0) begin
            pend_dbg = 1'b1; a_dbg = AW'($urandom_range(0, 15)); we_dbg = 1'($urandom);
            wd_dbg = $urandom;
         end
         if ($urandom_range(0, 15) == 0) halted = ~halted;
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL random ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL random data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
      end
      halted = 1'b0;
      for (int k = 0; k < 60 && active(); k++) begin
         step();
         n_chk++; if (obs_ctl !== exp_ctl) begin n_fail++;
            $display("FAIL random_drain ctl @%0d: got %h want %h", cyc, obs_ctl, exp_ctl); end
         n_chk++; if (obs_dat !== exp_dat) begin n_fail++;
            $display("FAIL random_drain data @%0d: got %h want %h", cyc, obs_dat, exp_dat); end
      end
      n_chk++; if (active()) begin n_fail++;
         $display("FAIL random_drain timeout: got pending want idle"); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; sel = 0; lat = 1;
      rst = 1'b1; halted = 1'b0; mem_clr = 1'b1;
      pend_if = 1'b0; pend_dm = 1'b0; pend_dbg = 1'b0; we_dm = 1'b0; we_dbg = 1'b0;
      a_if = '0; a_dm = '0; a_dbg = '0; wd_dm = '0; wd_dbg = '0;
      m_busy = 1'b0; m_wr = 1'b0; m_due = 0; m_owner = 0; m_starve = 0; m_data = '0;
      if_req = 1'b0; dm_req = 1'b0; dbg_req = 1'b0; dm_we = 1'b0; dbg_we = 1'b0;
      if_addr = '0; dm_addr = '0; dbg_addr = '0; dm_wdata = '0; dbg_wdata = '0;
      @(posedge clk);
      #1;
      mem_clr = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         lat = (s == 0) ? 1 : 3;
         rst = 1'b1;
         step();
         step();
         rst = 1'b0;
         test_reset();
         test_dbg_wr_rd();
         test_if_dm_same();
         test_starve();
         test_all_three();
         test_halted();
         if (lat == 3) test_reset_mid();
         test_random();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
